bmf_stream_decoder: RTL and testbench

Streaming, run-time-programmable decompressor for Boolean-matrix-factorised approximate partitions. Each accepted K-bit latent vector k is expanded into an M-bit partition output through a stored K x M basis matrix H: po[j] = OR over i of (k[i] & H[i][j]), or the GF(2) XOR of the same terms. It is the receiving end of a partition's compressor stage. Behind one register stage it replaces a hard-wired h-decoder, so a characterisation bench can swap factorisations without re-synthesis.

---
 rtl/bmf_pkg.sv | 17 +
 rtl/bmf_row_combine.sv | 28 ++
 rtl/bmf_stream_decoder.sv | 122 ++++++++++++
 tb/tb_bmf_stream_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bmf_pkg.sv
// Shared types and defaults for the Boolean-matrix-factorisation stream decoder.
package bmf_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  localparam int DEF_K = 7;
  localparam int DEF_M = 8;

endpackage

// File: rtl/bmf_row_combine.sv
// Combinational expansion of a latent vector through a flattened K x M basis,
// OR-ing or XOR-ing together the rows selected by set bits of k.
module bmf_row_combine
  import bmf_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int M = DEF_M
) (
  input  logic [K*M-1:0] h_i,
  input  logic [K-1:0]   k_i,
  input  logic           mode_i,
  output logic [M-1:0]   po_o
);

  always_comb begin
    po_o = '0;
    for (int i = 0; i < K; i++) begin
      if (k_i[i]) begin
        if (mode_i == MODE_XOR) begin
          po_o = po_o ^ h_i[i*M +: M];
        end else begin
          po_o = po_o | h_i[i*M +: M];
        end
      end
    end
  end

endmodule

// File: rtl/bmf_stream_decoder.sv
// Run-time programmable BMF decompressor: holds the basis matrix H and mode,
// decodes each accepted latent vector into one registered partition word.
module bmf_stream_decoder
  import bmf_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int M  = DEF_M,
  parameter int RW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [RW-1:0] cfg_row,
  input  logic [M-1:0]  cfg_data,
  input  logic          cfg_last,
  input  logic          cfg_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_po,
  output logic          loaded,
  output logic          cfg_err
);

  state_e         state_q;
  logic [K*M-1:0] h_q;
  logic           mode_q;
  logic           out_valid_q;
  logic [M-1:0]   out_po_q;
  logic           cfg_err_q;
  logic           loaded_q;

  logic           cfg_fire;
  logic           in_fire;
  logic           row_ok;
  logic [M-1:0]   po_d;

  // A pending cfg_valid in RUN blocks new input so H never changes under a live word.
  assign cfg_ready = (state_q == UNCFG) || (state_q == LOAD);
  assign in_ready  = (state_q == RUN) && !cfg_valid && (!out_valid_q || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign row_ok    = (32'(cfg_row) < 32'(K));

  bmf_row_combine #(
    .K(K),
    .M(M)
  ) u_row_combine (
    .h_i   (h_q),
    .k_i   (in_k),
    .mode_i(mode_q),
    .po_o  (po_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNCFG;
      h_q         <= '0;
      mode_q      <= MODE_OR;
      out_valid_q <= 1'b0;
      out_po_q    <= '0;
      cfg_err_q   <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      if (cfg_fire) begin
        for (int i = 0; i < K; i++) begin
          if (row_ok && (cfg_row == RW'(i))) begin
            h_q[i*M +: M] <= cfg_data;
          end
        end
        if (!row_ok) begin
          cfg_err_q <= 1'b1;
        end
      end

      if (in_fire) begin
        out_po_q    <= po_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        UNCFG, LOAD: begin
          if (cfg_fire) begin
            if (cfg_last) begin
              mode_q   <= cfg_mode;
              state_q  <= RUN;
              loaded_q <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        RUN: begin
          if (cfg_valid) begin
            state_q  <= DRAIN;
            loaded_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!out_valid_q) begin
            state_q <= LOAD;
          end
        end
        default: begin
          state_q  <= UNCFG;
          loaded_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_po    = out_po_q;
  assign loaded    = loaded_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_bmf_stream_decoder.sv
// Directed self-checking bench for bmf_stream_decoder with hand-computed expected words.
module tb_bmf_stream_decoder;

  localparam int K  = 7;
  localparam int M  = 8;
  localparam int RW = 3;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [RW-1:0] cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_last;
  logic          cfg_mode;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_k;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_po;
  logic          loaded;
  logic          cfg_err;

  int vectors;
  int miscompares;

  bmf_stream_decoder #(
    .K (K),
    .M (M),
    .RW(RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_row  (cfg_row),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .cfg_mode (cfg_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_k     (in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_po   (out_po),
    .loaded   (loaded),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One config beat; waits (bounded) for cfg_ready, then lets the edge accept it.
  task automatic cfgBeat(input logic [RW-1:0] row, input logic [M-1:0] data,
                         input logic last, input logic mode);
    cfg_valid = 1'b1;
    cfg_row   = row;
    cfg_data  = data;
    cfg_last  = last;
    cfg_mode  = mode;
    for (int i = 0; i < 20 && !cfg_ready; i++) step();
    checkOutput("cfgReady", 16'(cfg_ready), 16'h1);
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Present k, wait for acceptance, and require the decoded word exactly one cycle later.
  task automatic applyStimulus(input logic [K-1:0] k, input logic [M-1:0] expected,
                               input string tag);
    in_valid = 1'b1;
    in_k     = k;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    checkOutput({tag, "_inReady"}, 16'(in_ready), 16'h1);
    step();
    in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 16'(out_valid), 16'h1);
    checkOutput(tag, 16'(out_po), 16'(expected));
  endtask

  logic [M-1:0] got[$];
  logic [K-1:0] kList[3];
  int           sent;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_row     = '0;
    cfg_data    = '0;
    cfg_last    = 1'b0;
    cfg_mode    = 1'b0;
    in_valid    = 1'b0;
    in_k        = '0;
    out_ready   = 1'b1;

    #3;
    checkOutput("rstOutValid", 16'(out_valid), 16'h0);
    checkOutput("rstOutPo", 16'(out_po), 16'h0);
    checkOutput("rstCfgErr", 16'(cfg_err), 16'h0);
    checkOutput("rstLoaded", 16'(loaded), 16'h0);
    checkOutput("rstCfgReady", 16'(cfg_ready), 16'h1);
    checkOutput("rstInReady", 16'(in_ready), 16'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] copy mapping, OR mode");
    cfgBeat(3'd0, 8'h03, 1'b0, 1'b0);
    checkOutput("loadNotLoaded", 16'(loaded), 16'h0);
    cfgBeat(3'd1, 8'h04, 1'b0, 1'b0);
    cfgBeat(3'd2, 8'h08, 1'b0, 1'b0);
    cfgBeat(3'd3, 8'h10, 1'b0, 1'b0);
    cfgBeat(3'd4, 8'h20, 1'b0, 1'b0);
    cfgBeat(3'd5, 8'h40, 1'b0, 1'b0);
    cfgBeat(3'd6, 8'h80, 1'b1, 1'b0);
    checkOutput("runLoaded", 16'(loaded), 16'h1);
    checkOutput("runCfgReady", 16'(cfg_ready), 16'h0);
    applyStimulus(7'h01, 8'h03, "copyK01");
    applyStimulus(7'h7F, 8'hFF, "copyK7F");
    applyStimulus(7'h00, 8'h00, "copyK00");

    $display("[TB] XOR mode");
    cfgBeat(3'd0, 8'h03, 1'b0, 1'b0);
    cfgBeat(3'd1, 8'h01, 1'b0, 1'b0);
    cfgBeat(3'd2, 8'h00, 1'b0, 1'b0);
    cfgBeat(3'd3, 8'h00, 1'b0, 1'b0);
    cfgBeat(3'd4, 8'h00, 1'b0, 1'b0);
    cfgBeat(3'd5, 8'h00, 1'b0, 1'b0);
    cfgBeat(3'd6, 8'h00, 1'b1, 1'b1);
    applyStimulus(7'h03, 8'h02, "xorK03");
    applyStimulus(7'h01, 8'h03, "xorK01");
    applyStimulus(7'h00, 8'h00, "xorK00");

    cfg_valid = 1'b1;
    #1;
    checkOutput("cfgBlocksInput", 16'(in_ready), 16'h0);
    cfgBeat(3'd0, 8'h03, 1'b1, 1'b0);
    applyStimulus(7'h03, 8'h03, "orK03");

    $display("[TB] backpressure");
    cfgBeat(3'd1, 8'h04, 1'b0, 1'b0);
    cfgBeat(3'd2, 8'h08, 1'b1, 1'b0);
    kList[0] = 7'h01;
    kList[1] = 7'h02;
    kList[2] = 7'h04;
    sent     = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (sent < 3);
      in_k      = kList[(sent < 3) ? sent : 2];
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        checkOutput("bpHoldPo", 16'(out_po), 16'h03);
        checkOutput("bpHoldValid", 16'(out_valid), 16'h1);
        checkOutput("bpInReady", 16'(in_ready), 16'h0);
      end
      if (out_valid && out_ready) got.push_back(out_po);
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bpCount", 16'(got.size()), 16'd3);
    if (got.size() == 3) begin
      checkOutput("bpWord0", 16'(got[0]), 16'h03);
      checkOutput("bpWord1", 16'(got[1]), 16'h04);
      checkOutput("bpWord2", 16'(got[2]), 16'h08);
    end

    $display("[TB] reconfigure mid-stream");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_k      = 7'h01;
    step();
    in_valid = 1'b0;
    checkOutput("oldHWord", 16'(out_po), 16'h03);
    cfg_valid = 1'b1;
    cfg_row   = 3'd0;
    cfg_data  = 8'h80;
    cfg_last  = 1'b1;
    cfg_mode  = 1'b0;
    in_valid  = 1'b1;
    #1;
    checkOutput("inReadyDrop", 16'(in_ready), 16'h0);
    step();
    checkOutput("drainLoaded", 16'(loaded), 16'h0);
    checkOutput("drainCfgReady", 16'(cfg_ready), 16'h0);
    checkOutput("drainInReady", 16'(in_ready), 16'h0);
    step();
    checkOutput("drainHoldValid", 16'(out_valid), 16'h1);
    checkOutput("drainHoldPo", 16'(out_po), 16'h03);
    checkOutput("drainCfgBlocked", 16'(cfg_ready), 16'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !cfg_ready; i++) step();
    checkOutput("reloadCfgReady", 16'(cfg_ready), 16'h1);
    checkOutput("reloadOutDrained", 16'(out_valid), 16'h0);
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    checkOutput("reloadLoaded", 16'(loaded), 16'h1);
    applyStimulus(7'h01, 8'h80, "newHK01");

    $display("[TB] bad row index");
    cfgBeat(3'd7, 8'hFF, 1'b1, 1'b0);
    checkOutput("badRowErr", 16'(cfg_err), 16'h1);
    checkOutput("badRowLoaded", 16'(loaded), 16'h1);
    applyStimulus(7'h7F, 8'h8C, "badRowNoWrite");

    $display("[TB] reset during LOAD");
    cfgBeat(3'd3, 8'h11, 1'b0, 1'b1);
    cfgBeat(3'd4, 8'h22, 1'b0, 1'b1);
    cfgBeat(3'd5, 8'h44, 1'b0, 1'b1);
    checkOutput("errSticky", 16'(cfg_err), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstErr", 16'(cfg_err), 16'h0);
    checkOutput("asyncRstLoaded", 16'(loaded), 16'h0);
    checkOutput("asyncRstValid", 16'(out_valid), 16'h0);
    checkOutput("asyncRstCfgReady", 16'(cfg_ready), 16'h1);
    #2;
    rst_n = 1'b1;
    step();
    cfgBeat(3'd0, 8'h01, 1'b1, 1'b0);
    checkOutput("postRstLoaded", 16'(loaded), 16'h1);
    applyStimulus(7'h7F, 8'h01, "postRstDecode");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
